// File: rtl/mem_latency_model_if.sv
// rtl/mem_latency_model_if.sv - core-side instruction/data bus of the memory model
interface mem_latency_model_if;
  logic [31:0] IAD;
  logic [31:0] IDT;
  logic        ACKI_n;
  logic [31:0] DAD;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic        ACKD_n;

  modport master (output IAD, DAD, MREQ, WRITE, SIZE, input IDT, ACKI_n, ACKD_n);
  modport slave  (input IAD, DAD, MREQ, WRITE, SIZE, output IDT, ACKI_n, ACKD_n);
endinterface

// File: rtl/mem_latency_model.sv
// rtl/mem_latency_model.sv - instruction/data memory model with programmable ACK latency and MMIO decode
module mem_latency_model #(
  parameter int unsigned IMEM_LATENCY = 1,
  parameter int unsigned DMEM_LATENCY = 1,
  parameter logic [31:0] IMEM_START   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH   = 65536,
  parameter logic [31:0] DMEM_START   = 32'h0800_0000,
  parameter int unsigned DMEM_DEPTH   = 65536,
  parameter logic [31:0] STDOUT_ADDR  = 32'hf000_0000,
  parameter logic [31:0] EXIT_ADDR    = 32'hff00_0000
) (
  input  logic                clk,
  input  logic                rst,
  mem_latency_model_if.slave  bus,
  inout  wire  [31:0]         DDT,
  output logic                stdout_valid,
  output logic [7:0]          stdout_char,
  output logic                exit_o,
  output logic                err_o
);

  // imem occupies the low part of one byte array, dmem follows it
  localparam int unsigned MEM_BYTES = IMEM_DEPTH + DMEM_DEPTH;
  localparam int          AW        = $clog2(MEM_BYTES);
  localparam logic [3:0]  I_LAT     = 4'(IMEM_LATENCY);
  localparam logic [3:0]  D_LAT     = 4'(DMEM_LATENCY);
  localparam logic [31:0] I_LAST    = 32'(IMEM_DEPTH - 4);
  localparam logic [31:0] D_LAST_W  = 32'(DMEM_DEPTH - 4);
  localparam logic [31:0] D_LAST_H  = 32'(DMEM_DEPTH - 2);
  localparam logic [31:0] D_LAST_B  = 32'(DMEM_DEPTH - 1);

  logic [7:0]    mem [MEM_BYTES];

  logic [3:0]    i_cnt, i_cnt_nxt;
  logic [31:0]   i_addr, i_off;
  logic          i_start, i_done, i_ok;
  logic [AW-1:0] i_idx;
  logic [31:0]   i_word;

  logic [3:0]    d_cnt, d_cnt_nxt;
  logic [34:0]   d_key;
  logic          d_start, d_done, d_in_mem, d_mem_access, d_err;
  logic          is_stdout, is_exit;
  logic [31:0]   d_lo, d_off, d_last, ld_data, d_rdata;
  logic [AW-1:0] d_idx;
  logic [7:0]    d_m0, d_m1, d_m2, d_m3;
  logic          d_drive;

  // Fetch: a new or changed address restarts the count; completion when it reaches the latency
  always_comb begin
    i_start   = (i_cnt == 4'd0) || (bus.IAD != i_addr);
    i_cnt_nxt = i_start ? 4'd1 : i_cnt + 4'd1;
    i_done    = (i_cnt_nxt == I_LAT);
    i_off     = bus.IAD - IMEM_START;
    i_ok      = (bus.IAD >= IMEM_START) && (i_off <= I_LAST);
    i_idx     = AW'(i_off);
    i_word    = {mem[i_idx], mem[i_idx + AW'(1)], mem[i_idx + AW'(2)], mem[i_idx + AW'(3)]};
  end

  // Data: restart on any change of the request, decode byte lanes, region and MMIO targets
  always_comb begin
    d_start   = (d_cnt == 4'd0) || ({bus.DAD, bus.WRITE, bus.SIZE} != d_key);
    d_cnt_nxt = d_start ? 4'd1 : d_cnt + 4'd1;
    d_done    = bus.MREQ && (d_cnt_nxt == D_LAT);
    d_lo      = bus.DAD;
    d_last    = D_LAST_W;
    case (bus.SIZE)
      2'b00: begin
        d_lo   = bus.DAD;
        d_last = D_LAST_W;
      end
      2'b01: begin
        d_lo   = {bus.DAD[31:2], 2'b10} - {30'd0, bus.DAD[1:0]};
        d_last = D_LAST_H;
      end
      default: begin
        d_lo   = {bus.DAD[31:2], 2'b11} - {30'd0, bus.DAD[1:0]};
        d_last = D_LAST_B;
      end
    endcase
    d_off        = d_lo - DMEM_START;
    d_in_mem     = (d_lo >= DMEM_START) && (d_off <= d_last);
    is_stdout    = (bus.DAD == STDOUT_ADDR);
    is_exit      = (bus.DAD == EXIT_ADDR);
    d_mem_access = d_in_mem && !is_stdout && !is_exit;
    d_err        = !(d_in_mem || is_stdout || is_exit);
    d_idx        = AW'(IMEM_DEPTH) + AW'(d_off);
    d_m0         = mem[d_idx];
    d_m1         = mem[d_idx + AW'(1)];
    d_m2         = mem[d_idx + AW'(2)];
    d_m3         = mem[d_idx + AW'(3)];
    ld_data      = 32'd0;
    if (d_mem_access) begin
      case (bus.SIZE)
        2'b00:   ld_data = {d_m0, d_m1, d_m2, d_m3};
        2'b01:   ld_data = {16'd0, d_m0, d_m1};
        default: ld_data = {24'd0, d_m0};
      endcase
    end
  end

  // Fetch counter and instruction register; ACKI_n low for the cycle after completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_cnt      <= 4'd0;
      i_addr     <= 32'd0;
      bus.IDT    <= 32'd0;
      bus.ACKI_n <= 1'b1;
    end else begin
      i_cnt      <= i_done ? 4'd0 : i_cnt_nxt;
      if (i_start) i_addr <= bus.IAD;
      bus.ACKI_n <= !i_done;
      if (i_done) bus.IDT <= i_ok ? i_word : 32'd0;
    end
  end

  // Data counter, load return, MMIO side effects and error strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_cnt        <= 4'd0;
      d_key        <= 35'd0;
      d_rdata      <= 32'd0;
      d_drive      <= 1'b0;
      bus.ACKD_n   <= 1'b1;
      stdout_valid <= 1'b0;
      stdout_char  <= 8'd0;
      exit_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      if (!bus.MREQ) d_cnt <= 4'd0;
      else           d_cnt <= d_done ? 4'd0 : d_cnt_nxt;
      if (bus.MREQ && d_start) d_key <= {bus.DAD, bus.WRITE, bus.SIZE};
      bus.ACKD_n   <= !d_done;
      d_drive      <= d_done && !bus.WRITE;
      if (d_done && !bus.WRITE) d_rdata <= ld_data;
      stdout_valid <= d_done && bus.WRITE && is_stdout && bus.SIZE[1];
      if (d_done && bus.WRITE && is_stdout && bus.SIZE[1]) stdout_char <= DDT[7:0];
      if (d_done && bus.WRITE && is_exit) exit_o <= 1'b1;
      err_o        <= (i_done && !i_ok) || (d_done && d_err);
    end
  end

  // Memory contents survive reset; only completed in-range stores land, never while in reset
  always_ff @(posedge clk) begin
    if (rst && d_done && bus.WRITE && d_mem_access) begin
      case (bus.SIZE)
        2'b00: begin
          mem[d_idx]          <= DDT[31:24];
          mem[d_idx + AW'(1)] <= DDT[23:16];
          mem[d_idx + AW'(2)] <= DDT[15:8];
          mem[d_idx + AW'(3)] <= DDT[7:0];
        end
        2'b01: begin
          mem[d_idx]          <= DDT[15:8];
          mem[d_idx + AW'(1)] <= DDT[7:0];
        end
        default: mem[d_idx]   <= DDT[7:0];
      endcase
    end
  end

  assign DDT = d_drive ? d_rdata : 32'bz;

endmodule

// File: tb/tb_mem_latency_model.sv
// tb/tb_mem_latency_model.sv - directed self-checking bench for mem_latency_model
module tb_mem_latency_model;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  mem_latency_model_if bus_a ();
  mem_latency_model_if bus_b ();
  wire  [31:0] ddt_a, ddt_b;
  logic        drv_a, drv_b;
  logic [31:0] wd_a, wd_b;
  assign ddt_a = drv_a ? wd_a : 32'bz;
  assign ddt_b = drv_b ? wd_b : 32'bz;
  logic       so_v_a, so_v_b, exit_a, exit_b, err_a, err_b;
  logic [7:0] so_c_a, so_c_b;

  mem_latency_model #(.IMEM_LATENCY(1), .DMEM_LATENCY(2)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a), .DDT(ddt_a),
    .stdout_valid(so_v_a), .stdout_char(so_c_a), .exit_o(exit_a), .err_o(err_a));

  mem_latency_model #(.IMEM_LATENCY(3), .DMEM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b), .DDT(ddt_b),
    .stdout_valid(so_v_b), .stdout_char(so_c_b), .exit_o(exit_b), .err_o(err_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one data access on dut_a (sel=0) or dut_b (sel=1), wait for ACKD_n with a cycle budget
  task automatic data_access(input bit sel, input logic [31:0] a, input bit wr, input logic [1:0] sz,
                             input logic [31:0] wd, output logic [31:0] rd, output int lat,
                             output logic err, output logic sv, output logic [7:0] sc);
    logic ack;
    lat = 0; rd = 32'hx; err = 1'bx; sv = 1'bx; sc = 8'hx;
    if (sel) begin
      bus_b.DAD = a; bus_b.WRITE = wr; bus_b.SIZE = sz; bus_b.MREQ = 1'b1; wd_b = wd; drv_b = wr;
    end else begin
      bus_a.DAD = a; bus_a.WRITE = wr; bus_a.SIZE = sz; bus_a.MREQ = 1'b1; wd_a = wd; drv_a = wr;
    end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      ack = sel ? bus_b.ACKD_n : bus_a.ACKD_n;
      if (!ack) begin
        lat = k;
        rd  = sel ? ddt_b : ddt_a;
        err = sel ? err_b : err_a;
        sv  = sel ? so_v_b : so_v_a;
        sc  = sel ? so_c_b : so_c_a;
        break;
      end
    end
    if (sel) begin bus_b.MREQ = 1'b0; drv_b = 1'b0; end
    else     begin bus_a.MREQ = 1'b0; drv_a = 1'b0; end
  endtask

  logic [7:0]  img [12] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h00, 8'h40, 8'h02, 8'h93,
                            8'h12, 8'h34, 8'h56, 8'h78};
  logic [31:0] fexp [3] = '{32'h1305_1000, 32'h0040_0293, 32'h1234_5678};
  logic [31:0] rd;
  int          lat;
  logic        e, sv;
  logic [7:0]  sc;
  logic        ack_exp;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.IAD = 32'h0; bus_a.DAD = 32'h0; bus_a.MREQ = 1'b0; bus_a.WRITE = 1'b0; bus_a.SIZE = 2'b00;
    bus_b.IAD = 32'h4; bus_b.DAD = 32'h0; bus_b.MREQ = 1'b0; bus_b.WRITE = 1'b0; bus_b.SIZE = 2'b00;
    drv_a = 1'b0; drv_b = 1'b0; wd_a = 32'h0; wd_b = 32'h0;
    for (int i = 0; i < 12; i++) begin
      dut_a.mem[i] = img[i];
      dut_b.mem[i] = img[i];
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_acki", bus_a.ACKI_n, 1);
    check("rst_idt", bus_a.IDT, 0);
    check("rst_ackd", bus_a.ACKD_n, 1);
    check("rst_so_valid", so_v_a, 0);
    check("rst_so_char", so_c_a, 0);
    check("rst_exit", exit_a, 0);
    check("rst_err", err_a, 0);

    // IMEM_LATENCY=1: ACK every cycle, new instruction each cycle
    rst_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus_a.IAD = 32'(k * 4);
      @(posedge clk); @(negedge clk);
      check("fetch1_ack", bus_a.ACKI_n, 0);
      check("fetch1_idt", bus_a.IDT, fexp[k]);
    end

    // DMEM_LATENCY=2 loads/stores with big-endian lane mapping
    data_access(0, 32'h0800_0010, 1, 2'b00, 32'hdead_beef, rd, lat, e, sv, sc);
    check("st_word_lat", lat, 2);
    data_access(0, 32'h0800_0010, 0, 2'b00, 0, rd, lat, e, sv, sc);
    check("ld_word_lat", lat, 2);
    check("ld_word", rd, 32'hdead_beef);
    check("ld_word_err", e, 0);
    data_access(0, 32'h0800_0010, 0, 2'b01, 0, rd, lat, e, sv, sc);
    check("ld_half", rd, 32'h0000_beef);
    data_access(0, 32'h0800_0011, 0, 2'b10, 0, rd, lat, e, sv, sc);
    check("ld_byte", rd, 32'h0000_00be);

    // Console byte store
    data_access(0, 32'hf000_0000, 1, 2'b10, 32'h0000_0041, rd, lat, e, sv, sc);
    check("stdout_lat", lat, 2);
    check("stdout_valid", sv, 1);
    check("stdout_char", sc, 8'h41);
    @(posedge clk); @(negedge clk);
    check("stdout_valid_pulse", so_v_a, 0);
    check("stdout_char_hold", so_c_a, 8'h41);
    data_access(0, 32'h0800_0010, 0, 2'b00, 0, rd, lat, e, sv, sc);
    check("dmem_after_stdout", rd, 32'hdead_beef);

    // Half store lands in the upper-address lane pair
    data_access(0, 32'h0800_0010, 1, 2'b01, 32'h0000_1234, rd, lat, e, sv, sc);
    data_access(0, 32'h0800_0010, 0, 2'b00, 0, rd, lat, e, sv, sc);
    check("st_half_word", rd, 32'hdead_1234);

    // Out-of-range and region-end boundaries
    data_access(0, 32'h1000_0000, 0, 2'b00, 0, rd, lat, e, sv, sc);
    check("oor_lat", lat, 2);
    check("oor_data", rd, 0);
    check("oor_err", e, 1);
    @(posedge clk); @(negedge clk);
    check("oor_err_pulse", err_a, 0);
    data_access(0, 32'h0800_fffe, 0, 2'b00, 0, rd, lat, e, sv, sc);
    check("straddle_err", e, 1);
    data_access(0, 32'h0800_fffc, 0, 2'b00, 0, rd, lat, e, sv, sc);
    check("last_word_err", e, 0);
    data_access(0, 32'h0800_ffff, 0, 2'b10, 0, rd, lat, e, sv, sc);
    check("last_byte_err", e, 0);

    // Dropping MREQ mid-access aborts the store
    data_access(0, 32'h0800_0030, 1, 2'b00, 32'h0102_0304, rd, lat, e, sv, sc);
    bus_a.DAD = 32'h0800_0030; bus_a.WRITE = 1'b1; bus_a.SIZE = 2'b00; bus_a.MREQ = 1'b1;
    wd_a = 32'haaaa_aaaa; drv_a = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_no_ack0", bus_a.ACKD_n, 1);
    bus_a.MREQ = 1'b0; drv_a = 1'b0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("abort_no_ack", bus_a.ACKD_n, 1);
    end
    data_access(0, 32'h0800_0030, 0, 2'b00, 0, rd, lat, e, sv, sc);
    check("abort_mem", rd, 32'h0102_0304);

    // EXIT store is sticky, later accesses still served
    data_access(0, 32'hff00_0000, 1, 2'b00, 32'h0, rd, lat, e, sv, sc);
    check("exit_lat", lat, 2);
    check("exit_set", exit_a, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("exit_sticky", exit_a, 1);
    data_access(0, 32'h0800_0010, 0, 2'b00, 0, rd, lat, e, sv, sc);
    check("after_exit_ld", rd, 32'hdead_1234);

    // IMEM_LATENCY=3: ACK in cycles 3,6,9; address change after cycle 11 restarts, ACK at 14
    rst_b = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); @(negedge clk);
      ack_exp = !(k == 3 || k == 6 || k == 9 || k == 14);
      check("fetch3_ack", bus_b.ACKI_n, ack_exp);
      if (k == 3 || k == 9) check("fetch3_idt", bus_b.IDT, 32'h0040_0293);
      if (k == 14) check("fetch3_restart_idt", bus_b.IDT, 32'h1234_5678);
      if (k == 11) bus_b.IAD = 32'h8;
    end

    // Reset in the middle of a DMEM_LATENCY=3 store
    data_access(1, 32'hff00_0000, 1, 2'b00, 32'h0, rd, lat, e, sv, sc);
    check("b_exit", exit_b, 1);
    data_access(1, 32'h0800_0020, 1, 2'b00, 32'h1122_3344, rd, lat, e, sv, sc);
    check("b_st_lat", lat, 3);
    bus_b.DAD = 32'h0800_0020; bus_b.WRITE = 1'b1; bus_b.SIZE = 2'b00; bus_b.MREQ = 1'b1;
    wd_b = 32'hcafe_f00d; drv_b = 1'b1;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("b_pre_rst_ack", bus_b.ACKD_n, 1);
    end
    rst_b = 1'b0;
    #1;
    check("b_rst_acki", bus_b.ACKI_n, 1);
    check("b_rst_idt", bus_b.IDT, 0);
    check("b_rst_ackd", bus_b.ACKD_n, 1);
    check("b_rst_exit", exit_b, 0);
    check("b_rst_err", err_b, 0);
    check("b_rst_so_valid", so_v_b, 0);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("b_in_rst_ackd", bus_b.ACKD_n, 1);
    end
    bus_b.MREQ = 1'b0; drv_b = 1'b0;
    rst_b = 1'b1;
    data_access(1, 32'h0800_0020, 0, 2'b00, 0, rd, lat, e, sv, sc);
    check("b_ld_lat", lat, 3);
    check("b_mem_kept", rd, 32'h1122_3344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
